// File: rtl/stack_queue_ctrl.sv
// rtl/stack_queue_ctrl.sv - two-requester arbiter/sequencer for a shared LIFO/FIFO/buffer storage unit
// Optional STQ_CTRL_ERR_RSP_EN: grant illegal ops and answer them with an error response.
module stack_queue_ctrl #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_op,
    input  logic [2*DW-1:0] req_data,
    output logic [1:0]      req_ready,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_err,
    input  logic            cfg_valid,
    input  logic [1:0]      cfg_mode,
    output logic            cfg_ready,
    output logic [1:0]      st_mode,
    output logic            st_en_lifo,
    output logic            st_en_fifo,
    output logic            st_en_buffer,
    output logic [DW-1:0]   st_din,
    output logic            st_push,
    output logic            st_pop,
    output logic            st_reset,
    input  logic            st_empty,
    input  logic            st_full,
    input  logic [DW-1:0]   st_dout,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP, S_CLEAR, S_RECONF
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t      state, next_state;
    logic [1:0]  grant;
    logic [1:0]  op_ok;
    logic [1:0]  cand;
    logic        gnt_id;
    logic        rr;
    logic        op_q;
    logic        id_q;
    logic [1:0]  lat_cnt;
    logic [1:0]  mode_q;
    logic [2:0]  en_q;

    // BUFFER mode never refuses; otherwise status decides legality
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            op_ok[i] = (st_mode == 2'd2) || (req_op[i] ? !st_empty : !st_full);
        end
    end

`ifdef STQ_CTRL_ERR_RSP_EN
    logic err_q;
    assign cand = req_valid;
`else
    assign cand = req_valid & op_ok;
`endif

    assign gnt_id = grant[1];

    always_comb begin
        next_state = state;
        grant      = 2'b00;
        cfg_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_mode == 2'd3) cfg_ready = 1'b1;
                    else                  next_state = S_CLEAR;
                end else begin
                    // rr holds the last winner; on contention the other one goes
                    if (cand == 2'b11) grant = rr ? 2'b01 : 2'b10;
                    else               grant = cand;
`ifdef STQ_CTRL_ERR_RSP_EN
                    if (grant != 2'b00 && op_ok[gnt_id]) next_state = S_ISSUE;
`else
                    if (grant != 2'b00) next_state = S_ISSUE;
`endif
                end
            end
            S_ISSUE:   next_state = op_q ? S_WAIT_RD : S_IDLE;
            S_WAIT_RD: if (lat_cnt == 2'd0) next_state = S_RESP;
            S_RESP:    next_state = S_IDLE;
            S_CLEAR:   next_state = S_RECONF;
            S_RECONF: begin
                next_state = S_IDLE;
                cfg_ready  = 1'b1;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr       <= 1'b1;
            op_q     <= 1'b0;
            id_q     <= 1'b0;
            lat_cnt  <= 2'd0;
            mode_q   <= 2'd0;
            en_q     <= 3'b001;
            st_mode  <= 2'd0;
            st_reset <= 1'b1;
            st_din   <= '0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            state    <= next_state;
            st_reset <= (next_state == S_CLEAR);
            if (grant != 2'b00) rr <= gnt_id;
            if (state == S_IDLE && next_state == S_ISSUE) begin
                op_q   <= req_op[gnt_id];
                id_q   <= gnt_id;
                st_din <= gnt_id ? req_data[2*DW-1:DW] : req_data[DW-1:0];
            end
            if (state == S_ISSUE) lat_cnt <= LAT_INIT;
            else if (state == S_WAIT_RD && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
            if (state == S_WAIT_RD && lat_cnt == 2'd0) begin
                rsp_data <= st_dout;
                rsp_id   <= id_q;
            end
`ifdef STQ_CTRL_ERR_RSP_EN
            if (state == S_IDLE && grant != 2'b00 && !op_ok[gnt_id]) begin
                rsp_data <= '0;
                rsp_id   <= gnt_id;
            end
`endif
            if (state == S_IDLE && next_state == S_CLEAR) mode_q <= cfg_mode;
            // enables drop for the clear cycle, then come back one-hot in the new mode
            if (next_state == S_CLEAR) begin
                en_q <= 3'b000;
            end else if (next_state == S_RECONF) begin
                en_q    <= 3'b001 << mode_q;
                st_mode <= mode_q;
            end
        end
    end

`ifdef STQ_CTRL_ERR_RSP_EN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= (state == S_IDLE) && (grant != 2'b00) && !op_ok[gnt_id];
    end
    assign rsp_valid = (state == S_RESP) || err_q;
    assign rsp_err   = err_q;
`else
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = 1'b0;
`endif

    assign req_ready    = grant;
    assign st_push      = (state == S_ISSUE) && !op_q;
    assign st_pop       = (state == S_ISSUE) && op_q;
    assign st_en_lifo   = en_q[0];
    assign st_en_fifo   = en_q[1];
    assign st_en_buffer = en_q[2];
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_stack_queue_ctrl.sv
// tb/tb_stack_queue_ctrl.sv - directed self-checking bench for stack_queue_ctrl with a 4-deep storage model
module tb_stack_queue_ctrl;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_op, req_ready;
    logic [15:0] req_data;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_data;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_mode, st_mode;
    logic        st_en_lifo, st_en_fifo, st_en_buffer;
    logic [7:0]  st_din, st_dout;
    logic        st_push, st_pop, st_reset, st_empty, st_full, busy;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 CLK = ~CLK;

    stack_queue_ctrl #(.DW(8), .RD_LAT(1)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
        .st_mode(st_mode), .st_en_lifo(st_en_lifo), .st_en_fifo(st_en_fifo),
        .st_en_buffer(st_en_buffer), .st_din(st_din), .st_push(st_push), .st_pop(st_pop),
        .st_reset(st_reset), .st_empty(st_empty), .st_full(st_full), .st_dout(st_dout),
        .busy(busy)
    );

    // storage model: 4 entries, LIFO/FIFO by st_mode, single register in BUFFER mode
    logic [7:0] mem [4];
    logic [2:0] cnt;
    logic [7:0] buf_r;
    assign st_full  = (cnt == 3'd4);
    assign st_empty = (cnt == 3'd0);

    always @(posedge CLK) begin
        if (st_reset) begin
            cnt <= 3'd0;
        end else if (st_push && !st_full) begin
            if (st_mode == 2'd2) buf_r <= st_din;
            else begin
                mem[cnt[1:0]] <= st_din;
                cnt <= cnt + 3'd1;
            end
        end else if (st_pop) begin
            if (st_mode == 2'd2) st_dout <= buf_r;
            else if (cnt != 3'd0) begin
                if (st_mode == 2'd0) st_dout <= mem[cnt[1:0] - 2'd1];
                else begin
                    st_dout <= mem[0];
                    for (int k = 0; k < 3; k++) mem[k] <= mem[k+1];
                end
                cnt <= cnt - 3'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant(input int id);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("grant", 32'(ok), 32'd1);
    endtask

    task automatic do_push(input int id, input logic [7:0] d);
        req_valid[id] = 1'b1;
        req_op[id]    = 1'b0;
        req_data[id*8 +: 8] = d;
        wait_grant(id);
        tick();
        req_valid[id] = 1'b0;
        chk("push_strobe", 32'(st_push), 32'd1);
        chk("push_din", 32'(st_din), 32'(d));
        tick();
    endtask

    task automatic do_pop(input int id, input logic [7:0] exp);
        req_valid[id] = 1'b1;
        req_op[id]    = 1'b1;
        wait_grant(id);
        tick();
        req_valid[id] = 1'b0;
        chk("pop_strobe", 32'(st_pop), 32'd1);
        tick();
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        tick();
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_data  = 16'h0;
        cfg_valid = 1'b0;
        cfg_mode  = 2'd0;
        tick();
        tick();
        chk("rst_mode", 32'(st_mode), 32'd0);
        chk("rst_en", 32'({st_en_buffer, st_en_fifo, st_en_lifo}), 32'b001);
        chk("rst_streset", 32'(st_reset), 32'd1);
        chk("rst_strobes", 32'({st_push, st_pop, rsp_valid, cfg_ready, busy}), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("streset_drop", 32'(st_reset), 32'd0);

        // LIFO ordering
        do_push(0, 8'd3);
        do_push(0, 8'd4);
        do_push(0, 8'd1);
        do_pop(0, 8'd1);
        do_pop(0, 8'd4);
        do_pop(0, 8'd3);

        // pop on empty storage
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        #1;
`ifdef STQ_CTRL_ERR_RSP_EN
        chk("empty_grant", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("err_rsp", 32'({rsp_valid, rsp_err}), 32'b11);
        chk("err_data", 32'(rsp_data), 32'd0);
        chk("err_nopop", 32'({st_pop, busy}), 32'd0);
`else
        for (int i = 0; i < 3; i++) begin
            chk("empty_stall", 32'({req_ready[0], st_pop, busy}), 32'd0);
            tick();
            #1;
        end
        req_valid[0] = 1'b0;
`endif
        tick();

        // cfg arriving while a pop waits on read data
        do_push(1, 8'h07);
        req_valid[1] = 1'b1;
        req_op[1]    = 1'b1;
        wait_grant(1);
        tick();
        req_valid[1] = 1'b0;
        tick();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        chk("wr_busy", 32'(busy), 32'd1);
        tick();
        chk("wr_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b1, 8'h07}));
        chk("wr_nocfg", 32'({cfg_ready, st_reset}), 32'd0);
        tick();
        chk("wr_idle", 32'({busy, st_reset}), 32'd0);
        tick();
        chk("clr_pulse", 32'(st_reset), 32'd1);
        chk("clr_en", 32'({st_en_buffer, st_en_fifo, st_en_lifo}), 32'b000);
        tick();
        chk("reconf_ready", 32'(cfg_ready), 32'd1);
        chk("reconf_en", 32'({st_en_buffer, st_en_fifo, st_en_lifo}), 32'b010);
        chk("reconf_mode", 32'(st_mode), 32'd1);
        chk("clr_single", 32'(st_reset), 32'd0);
        cfg_valid = 1'b0;
        tick();
        chk("cfg_pulse", 32'(cfg_ready), 32'd0);

        // FIFO ordering
        do_push(0, 8'd3);
        do_push(0, 8'd4);
        do_push(0, 8'd1);
        do_pop(0, 8'd3);
        do_pop(0, 8'd4);
        do_pop(0, 8'd1);

        // reserved mode only acknowledges
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        #1;
        chk("rsv_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("rsv_keep", 32'({busy, st_reset, st_mode}), 32'({1'b0, 1'b0, 2'd1}));

        // reset during WAIT_RD drops the pop
        do_push(0, 8'h09);
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        wait_grant(0);
        tick();
        req_valid[0] = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'({st_en_buffer, st_en_fifo, st_en_lifo}), 32'b001);
        chk("mid_rst_sr", 32'(st_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_norsp", 32'(rsp_valid), 32'd0);
            tick();
        end

        // contention alternates, requester 0 first after reset
        req_valid = 2'b11;
        req_op    = 2'b00;
        req_data  = 16'h2010;
        for (int k = 0; k < 4; k++) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                #1;
                if (req_ready != 2'b00) got = 1'b1;
                else tick();
            end
            chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            chk("rr_din", 32'(st_din), (k % 2 == 0) ? 32'h10 : 32'h20);
            tick();
        end
        req_valid = 2'b00;

`ifndef STQ_CTRL_ERR_RSP_EN
        // storage full: push stalls until a pop frees space
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_stall", 32'(req_ready[1]), 32'd0);
            tick();
        end
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        wait_grant(0);
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        chk("full_pop", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h20}));
        tick();
        chk("full_release", 32'(req_ready), 32'b10);
        tick();
        req_valid[1] = 1'b0;
        chk("full_push", 32'({st_push, st_din}), 32'({1'b1, 8'h55}));
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
